// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit driving a single-outstanding request/response bus.
// Loads and stores stall the pipe through REQ/WAIT and present the formatted result in DONE.
module mem_access #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic [3:0]      mem_op_i,
   input  logic [XLEN-1:0] alu_result_i,
   input  logic [XLEN-1:0] store_data_i,
   input  logic [4:0]      rd_addr_i,
   output logic [XLEN-1:0] mem_data_o,
   output logic [4:0]      rd_addr_o,
   output logic            stall_o,
   output logic            misalign_o,
   output logic            bus_req_valid_o,
   input  logic            bus_req_ready_i,
   output logic [XLEN-1:0] bus_addr_o,
   output logic            bus_we_o,
   output logic [XLEN-1:0] bus_wdata_o,
   output logic [7:0]      bus_wstrb_o,
   input  logic            bus_resp_valid_i,
   input  logic [XLEN-1:0] bus_rdata_i
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
   state_t r_state, w_next;
   logic [XLEN-1:0] r_data, w_fmt, w_shift;
   logic w_load, w_store, w_mem, w_sign, w_mis, w_stall, w_cap;
   logic [1:0] w_size;
   logic [2:0] w_off;
   logic [7:0] w_mask;

   assign w_load  = mem_op_i >= 4'd1 && mem_op_i <= 4'd7;
   assign w_store = mem_op_i >= 4'd8 && mem_op_i <= 4'd11;
   assign w_mem   = w_load | w_store;
   assign w_sign  = mem_op_i >= 4'd1 && mem_op_i <= 4'd3;
   // op-1 maps LB..LD to 0..3 and LBU..LWU to 4..6, whose low bits are the same sizes
   assign w_size  = w_store ? mem_op_i[1:0] : 2'(mem_op_i - 4'd1);
   assign w_off   = alu_result_i[2:0];
   assign w_mis   = w_mem & (w_size == 2'd1 ? w_off[0] :
                             w_size == 2'd2 ? |w_off[1:0] :
                             w_size == 2'd3 ? |w_off : 1'b0);
   assign w_mask  = w_size == 2'd0 ? 8'h01 : w_size == 2'd1 ? 8'h03 :
                    w_size == 2'd2 ? 8'h0F : 8'hFF;

   assign rd_addr_o   = rd_addr_i;
   assign misalign_o  = w_mis;
   assign bus_addr_o  = {alu_result_i[XLEN-1:3], 3'b000};
   assign bus_we_o    = w_store;
   assign bus_wdata_o = store_data_i << {w_off, 3'b000};
   assign bus_wstrb_o = w_store ? 8'(w_mask << w_off) : 8'h00;
   assign stall_o     = w_stall & ~rst;

   assign w_shift = bus_rdata_i >> {w_off, 3'b000};
   assign w_fmt   = !w_load ? '0 :
                    w_size == 2'd0 ? {{(XLEN-8){w_sign & w_shift[7]}}, w_shift[7:0]} :
                    w_size == 2'd1 ? {{(XLEN-16){w_sign & w_shift[15]}}, w_shift[15:0]} :
                    w_size == 2'd2 ? {{(XLEN-32){w_sign & w_shift[31]}}, w_shift[31:0]} :
                    w_shift;

   always_comb begin
      w_next          = r_state;
      w_stall         = 1'b0;
      w_cap           = 1'b0;
      bus_req_valid_o = 1'b0;
      mem_data_o      = '0;
      case (r_state)
         IDLE: begin
            w_stall    = w_mem & ~w_mis & ~flush_i;
            mem_data_o = (flush_i | w_mem) ? '0 : alu_result_i;
            w_next     = w_stall ? REQ : IDLE;
         end
         REQ: begin
            w_stall         = 1'b1;
            bus_req_valid_o = 1'b1;
            w_next          = bus_req_ready_i ? (flush_i ? DRAIN : WAIT) : (flush_i ? IDLE : REQ);
         end
         WAIT: begin
            w_stall = 1'b1;
            w_cap   = bus_resp_valid_i & ~flush_i;
            w_next  = bus_resp_valid_i ? (flush_i ? IDLE : DONE) : (flush_i ? DRAIN : WAIT);
         end
         DONE: begin
            mem_data_o = flush_i ? '0 : r_data;
            w_next     = IDLE;
         end
         DRAIN: begin
            w_stall = 1'b1;
            w_next  = bus_resp_valid_i ? IDLE : DRAIN;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_data  <= '0;
      end else begin
         r_state <= w_next;
         if (w_cap) r_data <= w_fmt;
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized scoreboard bench for mem_access with directed flush/reset cases.
module tb_mem_access;
   logic clk = 1'b0, rst = 1'b1, flush = 1'b0, ready = 1'b0, resp = 1'b0;
   logic [3:0] op = '0;
   logic [63:0] alu = '0, sdata = '0, rdata = '0;
   logic [4:0] rd = '0;
   logic [63:0] mem_data, bus_addr, wdata;
   logic [4:0] rd_o;
   logic stall, mis, valid, we;
   logic [7:0] wstrb;
   int errors = 0, checks = 0;
   typedef struct {logic [63:0] data; logic mis; logic [4:0] rd;} exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   mem_access dut (
      .clk(clk), .rst(rst), .flush_i(flush), .mem_op_i(op), .alu_result_i(alu),
      .store_data_i(sdata), .rd_addr_i(rd), .mem_data_o(mem_data), .rd_addr_o(rd_o),
      .stall_o(stall), .misalign_o(mis), .bus_req_valid_o(valid), .bus_req_ready_i(ready),
      .bus_addr_o(bus_addr), .bus_we_o(we), .bus_wdata_o(wdata), .bus_wstrb_o(wstrb),
      .bus_resp_valid_i(resp), .bus_rdata_i(rdata)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: byte size from the opcode, alignment by modulo, result assembled byte by byte.
   function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] a, input logic fl,
                                         input logic [63:0] rdat, output logic m, output int sz,
                                         output logic st);
      logic [63:0] v;
      int off;
      logic sg;
      case (o)
         4'd1, 4'd5, 4'd8:  sz = 1;
         4'd2, 4'd6, 4'd9:  sz = 2;
         4'd3, 4'd7, 4'd10: sz = 4;
         4'd4, 4'd11:       sz = 8;
         default:           sz = 0;
      endcase
      st  = o >= 4'd8 && o <= 4'd11;
      sg  = o >= 4'd1 && o <= 4'd3;
      off = int'(a[2:0]);
      m   = sz != 0 && off % sz != 0;
      if (sz == 0) return fl ? 64'd0 : a;
      if (fl || m || st) return 64'd0;
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = rdat[8*(off+i) +: 8];
      if (sg && v[8*sz-1]) for (int i = 8*sz; i < 64; i++) v[i] = 1'b1;
      return v;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst && !stall && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("mem_data", mem_data, e.data);
         chk("misalign", 64'(mis), 64'(e.mis));
         chk("rd_addr", 64'(rd_o), 64'(e.rd));
      end
   end

   task automatic run_txn(input logic [3:0] o, input logic [63:0] a, input logic [63:0] sd,
                          input logic [63:0] rdat, input int rdy_dly, input int rsp_dly, input logic fl);
      exp_t e;
      int sz, n, r, stalls;
      logic st, acc, seen, done, go;
      int unsigned sm;
      n = 0; r = 0; stalls = 0; acc = 0; seen = 0; done = 0;
      e.data = model(o, a, fl, rdat, e.mis, sz, st);
      e.rd = 5'($urandom);
      go = sz != 0 && !e.mis && !fl;
      sm = ((32'd1 << sz) - 1) << a[2:0];
      op = o; alu = a; sdata = sd; rdata = rdat; flush = fl; rd = e.rd; ready = 0; resp = 0;
      exp_q.push_back(e);
      #1;
      for (int c = 0; c < 64 && !done; c++) begin
         if (!stall) done = 1;
         else begin
            stalls++;
            resp = acc && r == rsp_dly;
            if (acc) r++;
            if (valid) begin
               seen = 1;
               chk("bus_addr", bus_addr, {a[63:3], 3'b000});
               chk("bus_we", 64'(we), 64'(st));
               if (st) begin
                  chk("bus_wstrb", 64'(wstrb), 64'(sm[7:0]));
                  chk("bus_wdata", wdata, sd << (8 * int'(a[2:0])));
               end
               ready = n == rdy_dly;
               n++;
               if (ready) acc = 1;
            end
            step();
            ready = 0;
            resp = 0;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL timeout: op %0d addr %h never released stall", o, a);
         exp_q.delete();
         rst = 1; op = 0; flush = 0;
         step();
         rst = 0;
         return;
      end
      chk("req_seen", 64'(seen), 64'(go));
      if (go) chk("req_hold", 64'(n), 64'(rdy_dly + 1));
      if (go && rdy_dly == 0 && rsp_dly == 0) chk("latency", 64'(stalls), 64'd3);
      step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] o;
      logic [63:0] a;
      op = 4'd4; alu = 64'h100;
      #3;
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      op = 4'd0; alu = 64'h1234;
      #1 chk("rst_data", mem_data, 64'h1234);
      step();
      rst = 0;
      step();
      run_txn(4'd1, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 1'b0);
      run_txn(4'd9, 64'h1006, 64'h1234, 64'hDEAD_BEEF_0000_0000, 0, 0, 1'b0);
      run_txn(4'd3, 64'h1002, 64'd0, 64'h1, 0, 0, 1'b0);
      run_txn(4'd4, 64'h2000, 64'd0, 64'h0123_4567_89AB_CDEF, 5, 1, 1'b0);
      // flush one cycle after acceptance, response two cycles after that
      op = 4'd4; alu = 64'h3000;
      #1 chk("d48_idle_stall", 64'(stall), 64'd1);
      step(); chk("d48_req_valid", 64'(valid), 64'd1); ready = 1;
      step(); ready = 0; flush = 1;
      #1 chk("d48_wait_stall", 64'(stall), 64'd1);
      step(); flush = 0; op = 4'd0; alu = 64'h55;
      #1 chk("d48_drain_stall", 64'(stall), 64'd1); chk("d48_drain_valid", 64'(valid), 64'd0);
      step(); resp = 1;
      #1 chk("d48_drain_stall2", 64'(stall), 64'd1);
      step(); resp = 0;
      #1 chk("d48_idle_stall", 64'(stall), 64'd0); chk("d48_idle_data", mem_data, 64'h55);
      // reset in WAIT, then a late response
      op = 4'd4; alu = 64'h4000;
      step(); ready = 1;
      step(); ready = 0;
      #1 chk("d49_wait_stall", 64'(stall), 64'd1);
      #1 rst = 1;
      #1 chk("d49_rst_stall", 64'(stall), 64'd0); chk("d49_rst_valid", 64'(valid), 64'd0);
      rst = 0; op = 4'd0; alu = 64'hABCD;
      step(); resp = 1; rdata = 64'hFFFF;
      #1 chk("d49_late_data", mem_data, 64'hABCD); chk("d49_late_stall", 64'(stall), 64'd0);
      step(); resp = 0;
      #1 chk("d49_after_data", mem_data, 64'hABCD); chk("d49_after_valid", 64'(valid), 64'd0);
      // flush in REQ without ready withdraws
      op = 4'd4; alu = 64'h5000;
      step(); chk("fr_valid", 64'(valid), 64'd1); flush = 1;
      step(); flush = 0; op = 4'd0; alu = 64'h77;
      #1 chk("fr_stall", 64'(stall), 64'd0); chk("fr_valid_off", 64'(valid), 64'd0);
      chk("fr_data", mem_data, 64'h77);
      // flush in REQ with ready goes to DRAIN
      op = 4'd4; alu = 64'h6000;
      step(); flush = 1; ready = 1;
      step(); flush = 0; ready = 0; op = 4'd0; alu = 64'h88;
      #1 chk("fa_drain_stall", 64'(stall), 64'd1); chk("fa_drain_valid", 64'(valid), 64'd0);
      resp = 1;
      step(); resp = 0;
      #1 chk("fa_idle_stall", 64'(stall), 64'd0); chk("fa_idle_data", mem_data, 64'h88);
      // flush in WAIT together with the response
      op = 4'd4; alu = 64'h7000;
      step(); ready = 1;
      step(); ready = 0; flush = 1; resp = 1; rdata = 64'h1111;
      step(); flush = 0; resp = 0; op = 4'd0; alu = 64'h99;
      #1 chk("fw_stall", 64'(stall), 64'd0); chk("fw_data", mem_data, 64'h99);
      // flush in DONE blanks the result
      op = 4'd1; alu = 64'h8000;
      step(); ready = 1;
      step(); ready = 0; resp = 1; rdata = 64'hFF;
      step(); resp = 0; flush = 1;
      #1 chk("fd_stall", 64'(stall), 64'd0); chk("fd_data", mem_data, 64'd0);
      step(); flush = 0; op = 4'd0; alu = 64'h11;
      #1 chk("fd_idle_data", mem_data, 64'h11);
      // stray response in IDLE
      alu = 64'h22; resp = 1; rdata = 64'hFFFF_FFFF;
      #1 chk("ri_data", mem_data, 64'h22);
      step(); resp = 0;
      #1 chk("ri_stall", 64'(stall), 64'd0); chk("ri_data2", mem_data, 64'h22);
      step();
      for (int k = 0; k < 200; k++) begin
         o = 4'($urandom_range(0, 15));
         a = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: a[2:0] = 3'b000;
            1: a[0] = 1'b0;
            default: ;
         endcase
         run_txn(o, a, {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9) == 0);
      end
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
